// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter that lets two requesters load, read or clear one register
// of a shared-bus register bank. It sequences the LD/CLR/OE_N strobes and drives
// or samples the shared data bus.
module reg_bus_arbiter #(
  parameter int unsigned NREG = 4,
  parameter int unsigned W    = 4
) (
  input  logic                      CLK,
  input  logic                      CLRN,
  input  logic [1:0]                REQ,
  input  logic [1:0]                OP0,
  input  logic [1:0]                OP1,
  input  logic [$clog2(NREG)-1:0]   ADDR0,
  input  logic [$clog2(NREG)-1:0]   ADDR1,
  input  logic [W-1:0]              DIN0,
  input  logic [W-1:0]              DIN1,
  input  logic [W-1:0]              BUS_IN,
  output logic [1:0]                ACK,
  output logic [W-1:0]              RDATA,
  output logic [W-1:0]              BUS_DRV,
  output logic                      BUS_EN,
  output logic [NREG-1:0]           LD,
  output logic [NREG-1:0]           CLR,
  output logic [NREG-1:0]           OE_N,
  output logic                      BUSY
);

  localparam int unsigned AW = $clog2(NREG);

  localparam logic [1:0] OpNop   = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [1:0] {StIdle, StExec, StSample, StDone} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;
  logic            pri_q, pri_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [W-1:0]    din_q, din_d;
  logic [W-1:0]    rdata_q, rdata_d;
  logic [NREG-1:0] ld_q, ld_d;
  logic [NREG-1:0] clr_q, clr_d;
  logic [NREG-1:0] oe_n_q, oe_n_d;
  logic            bus_en_q, bus_en_d;
  logic [W-1:0]    bus_drv_q, bus_drv_d;
  logic [1:0]      ack_q, ack_d;
  logic [NREG-1:0] hit;

  // Arbitration, request latch and state sequencing.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    pri_d   = pri_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (|REQ) begin
          grant_d = (REQ == 2'b11) ? pri_q : REQ[1];
          op_d    = grant_d ? OP1 : OP0;
          addr_d  = grant_d ? ADDR1 : ADDR0;
          din_d   = grant_d ? DIN1 : DIN0;
          state_d = StExec;
        end
      end
      StExec: begin
        // Out-of-range reads skip the sample cycle and behave as a nop.
        state_d = ((op_q == OpRead) && (|hit)) ? StSample : StDone;
      end
      StSample: begin
        rdata_d = BUS_IN;
        state_d = StDone;
      end
      StDone: begin
        pri_d   = ~grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // One-hot decode of the target register; all zero when the address is out of range.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      hit[i] = (addr_d == AW'(i));
    end
  end

  // Next values of the registered strobes, keyed on the state being entered.
  always_comb begin
    ld_d      = '0;
    clr_d     = '0;
    oe_n_d    = '1;
    bus_en_d  = 1'b0;
    bus_drv_d = '0;
    ack_d     = '0;
    unique case (state_d)
      StExec: begin
        unique case (op_d)
          OpLoad: begin
            if (|hit) begin
              ld_d      = hit;
              bus_en_d  = 1'b1;
              bus_drv_d = din_d;
            end
          end
          OpClear: clr_d  = hit;
          OpRead:  oe_n_d = ~hit;
          OpNop:   ;
          default: ;
        endcase
      end
      StSample: oe_n_d = ~hit;
      StDone:   ack_d[grant_d] = 1'b1;
      default:  ;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      pri_q     <= 1'b0;
      op_q      <= OpNop;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
      ld_q      <= '0;
      clr_q     <= '0;
      oe_n_q    <= '1;
      bus_en_q  <= 1'b0;
      bus_drv_q <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pri_q     <= pri_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rdata_q   <= rdata_d;
      ld_q      <= ld_d;
      clr_q     <= clr_d;
      oe_n_q    <= oe_n_d;
      bus_en_q  <= bus_en_d;
      bus_drv_q <= bus_drv_d;
      ack_q     <= ack_d;
    end
  end

  assign ACK     = ack_q;
  assign RDATA   = rdata_q;
  assign BUS_DRV = bus_drv_q;
  assign BUS_EN  = bus_en_q;
  assign LD      = ld_q;
  assign CLR     = clr_q;
  assign OE_N    = oe_n_q;
  assign BUSY    = (state_q != StIdle);

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: a 4-register main instance plus a
// 3-register instance sharing its inputs to exercise out-of-range addresses.
module tb_reg_bus_arbiter;

  logic       CLK = 1'b0;
  logic       CLRN;
  logic [1:0] REQ;
  logic [1:0] OP0, OP1;
  logic [1:0] ADDR0, ADDR1;
  logic [3:0] DIN0, DIN1;
  logic [3:0] BUS_IN;
  logic [1:0] ACK;
  logic [3:0] RDATA, BUS_DRV;
  logic       BUS_EN, BUSY;
  logic [3:0] LD, CLR, OE_N;

  logic [1:0] ACK3;
  logic [3:0] RDATA3, BUS_DRV3;
  logic       BUS_EN3, BUSY3;
  logic [2:0] LD3, CLR3, OE_N3;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         side;
    bit         is_read;
    logic [3:0] rdata;
  } sb_item_t;

  sb_item_t   sb[$];
  sb_item_t   mon_item;
  int         mon_side;
  logic [3:0] bank [4];

  always #5 CLK = ~CLK;

  reg_bus_arbiter #(.NREG(4), .W(4)) dut (
    .CLK(CLK), .CLRN(CLRN), .REQ(REQ), .OP0(OP0), .OP1(OP1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .DIN0(DIN0), .DIN1(DIN1), .BUS_IN(BUS_IN),
    .ACK(ACK), .RDATA(RDATA), .BUS_DRV(BUS_DRV), .BUS_EN(BUS_EN),
    .LD(LD), .CLR(CLR), .OE_N(OE_N), .BUSY(BUSY)
  );

  reg_bus_arbiter #(.NREG(3), .W(4)) dut3 (
    .CLK(CLK), .CLRN(CLRN), .REQ(REQ), .OP0(OP0), .OP1(OP1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .DIN0(DIN0), .DIN1(DIN1), .BUS_IN(BUS_IN),
    .ACK(ACK3), .RDATA(RDATA3), .BUS_DRV(BUS_DRV3), .BUS_EN(BUS_EN3),
    .LD(LD3), .CLR(CLR3), .OE_N(OE_N3), .BUSY(BUSY3)
  );

  // Register bank model driven by the main instance's strobes.
  always @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (LD[i] && BUS_EN) bank[i] <= BUS_DRV;
      else if (CLR[i])     bank[i] <= 4'h0;
    end
  end

  always_comb begin
    BUS_IN = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (!OE_N[i]) BUS_IN = bank[i];
    end
  end

  // Scoreboard and invariant monitor.
  always @(negedge CLK) begin
    if (CLRN) begin
      checks++;
      if (($countones(LD) + $countones(CLR) + $countones(~OE_N)) > 1) begin
        failures++;
        $display("FAIL strobe_exclusive: LD=%b CLR=%b OE_N=%b, at most one active required",
                 LD, CLR, OE_N);
      end
      checks++;
      if (BUS_EN && (OE_N != 4'hF)) begin
        failures++;
        $display("FAIL bus_conflict: BUS_EN=1 with OE_N=%b, required OE_N=1111", OE_N);
      end
      checks++;
      if (!BUS_EN && (BUS_DRV != 4'h0)) begin
        failures++;
        $display("FAIL bus_drv_idle: BUS_DRV=%h with BUS_EN=0, required 0", BUS_DRV);
      end
      if (ACK != 2'b00) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL ack_unexpected: ACK=%b, required 00", ACK);
        end else begin
          mon_item = sb.pop_front();
          mon_side = ACK[1] ? 1 : 0;
          if ((ACK == 2'b11) || (mon_side != mon_item.side)) begin
            failures++;
            $display("FAIL ack_side: ACK=%b, required requester %0d", ACK, mon_item.side);
          end
          if (mon_item.is_read) begin
            checks++;
            if (RDATA !== mon_item.rdata) begin
              failures++;
              $display("FAIL rdata: RDATA=%h, required %h", RDATA, mon_item.rdata);
            end
          end
        end
      end
    end
  end

  task automatic run_txn(input int side, input logic [1:0] op, input logic [1:0] addr,
                         input logic [3:0] din, input logic [3:0] exp_rd, input bit chg,
                         output int lat3, output int str3);
    sb_item_t   it;
    int         lat;
    int         exp_lat;
    bit         got;
    logic [3:0] e_ld, e_clr, e_oen, e_drv;
    logic       e_en;
    if (side == 0) begin
      OP0 = op; ADDR0 = addr; DIN0 = din;
    end else begin
      OP1 = op; ADDR1 = addr; DIN1 = din;
    end
    REQ[side] = 1'b1;
    it.side = side; it.is_read = (op == 2'b10); it.rdata = exp_rd;
    sb.push_back(it);
    e_ld = 4'h0; e_clr = 4'h0; e_oen = 4'hF; e_drv = 4'h0; e_en = 1'b0;
    case (op)
      2'b01: begin e_ld[addr] = 1'b1; e_en = 1'b1; e_drv = din; end
      2'b10: e_oen[addr] = 1'b0;
      2'b11: e_clr[addr] = 1'b1;
      default: ;
    endcase
    exp_lat = (op == 2'b10) ? 3 : 2;
    lat = 0; got = 1'b0; lat3 = 0; str3 = 0;
    while (!got && lat < 12) begin
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        if (chg) begin
          if (side == 0) DIN0 = ~din; else DIN1 = ~din;
          #1;
        end
        checks++;
        if ({LD, CLR, OE_N, BUS_EN, BUS_DRV} !== {e_ld, e_clr, e_oen, e_en, e_drv}) begin
          failures++;
          $display("FAIL exec_strobes: LD=%b CLR=%b OE_N=%b EN=%b DRV=%h, required %b %b %b %b %h",
                   LD, CLR, OE_N, BUS_EN, BUS_DRV, e_ld, e_clr, e_oen, e_en, e_drv);
        end
      end
      if (lat == 2 && op == 2'b10) begin
        checks++;
        if (OE_N !== e_oen) begin
          failures++;
          $display("FAIL sample_oe: OE_N=%b, required %b", OE_N, e_oen);
        end
      end
      if (ACK3[side] && lat3 == 0) lat3 = lat;
      if (LD3 != 3'b0 || CLR3 != 3'b0 || OE_N3 != 3'b111 || BUS_EN3) str3++;
      if (ACK[side]) got = 1'b1;
    end
    checks++;
    if (!got || lat != exp_lat) begin
      failures++;
      $display("FAIL ack_latency: got=%0d cycles=%0d, required ack after %0d", got, lat, exp_lat);
    end
    REQ[side] = 1'b0;
    @(negedge CLK);
    checks++;
    if (ACK[side] !== 1'b0) begin
      failures++;
      $display("FAIL ack_single: ACK=%b one cycle later, required 0 on side %0d", ACK, side);
    end
  endtask

  task automatic test_reset();
    logic [5:0] l3;
    REQ = 2'b11; OP0 = 2'b01; ADDR0 = 2'd1; DIN0 = 4'h5;
    OP1 = 2'b01; ADDR1 = 2'd2; DIN1 = 4'h6;
    repeat (3) @(negedge CLK);
    checks++;
    if ({ACK, LD, CLR, OE_N, BUS_EN, BUS_DRV, RDATA, BUSY} !==
        {2'b00, 4'h0, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: ACK=%b LD=%b CLR=%b OE_N=%b EN=%b DRV=%h RD=%h BUSY=%b",
               ACK, LD, CLR, OE_N, BUS_EN, BUS_DRV, RDATA, BUSY);
    end
    l3 = {LD3, CLR3};
    checks++;
    if (l3 !== 6'b0 || OE_N3 !== 3'b111) begin
      failures++;
      $display("FAIL reset_outputs3: LD/CLR=%b OE_N=%b, required 0/111", l3, OE_N3);
    end
    CLRN = 1'b1;
    @(negedge CLK);
    checks++;
    if (LD !== 4'b0010 || BUS_DRV !== 4'h5 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL first_grant: LD=%b DRV=%h BUSY=%b, required 0010 5 1", LD, BUS_DRV, BUSY);
    end
    CLRN = 1'b0;
    REQ  = 2'b00;
    #1;
    checks++;
    if (LD !== 4'h0 || ACK !== 2'b00 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: LD=%b ACK=%b BUSY=%b, required 0000 00 0", LD, ACK, BUSY);
    end
    @(negedge CLK);
    CLRN = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_load_read();
    int l3, s3;
    run_txn(0, 2'b01, 2'd2, 4'hA, 4'h0, 1'b0, l3, s3);
    run_txn(0, 2'b10, 2'd2, 4'h0, 4'hA, 1'b0, l3, s3);
  endtask

  task automatic test_contention();
    sb_item_t it;
    int acks, cyc, l3, s3;
    CLRN = 1'b0;
    @(negedge CLK);
    CLRN = 1'b1;
    OP0 = 2'b01; ADDR0 = 2'd0; DIN0 = 4'h1;
    OP1 = 2'b01; ADDR1 = 2'd1; DIN1 = 4'h9;
    for (int i = 0; i < 4; i++) begin
      it.side = i % 2; it.is_read = 1'b0; it.rdata = 4'h0;
      sb.push_back(it);
    end
    REQ = 2'b11;
    acks = 0; cyc = 0;
    while (acks < 4 && cyc < 30) begin
      @(negedge CLK);
      cyc++;
      if (ACK[0]) begin acks++; DIN0 = DIN0 + 4'h1; end
      if (ACK[1]) begin acks++; DIN1 = DIN1 + 4'h1; end
    end
    REQ = 2'b00;
    checks++;
    if (acks != 4 || cyc != 11) begin
      failures++;
      $display("FAIL contention_rate: acks=%0d cycles=%0d, required 4 acks at cycle 11", acks, cyc);
    end
    @(negedge CLK);
    run_txn(0, 2'b10, 2'd0, 4'h0, 4'h2, 1'b0, l3, s3);
    run_txn(0, 2'b10, 2'd1, 4'h0, 4'hA, 1'b0, l3, s3);
  endtask

  task automatic test_clear_oor();
    int l3, s3;
    run_txn(1, 2'b01, 2'd3, 4'h7, 4'h0, 1'b0, l3, s3);
    checks++;
    if (l3 != 2 || s3 != 0) begin
      failures++;
      $display("FAIL oor_load: ack3 at %0d strobes=%0d, required 2 and 0", l3, s3);
    end
    run_txn(1, 2'b11, 2'd3, 4'h0, 4'h0, 1'b0, l3, s3);
    checks++;
    if (l3 != 2 || s3 != 0) begin
      failures++;
      $display("FAIL oor_clear: ack3 at %0d strobes=%0d, required 2 and 0", l3, s3);
    end
    run_txn(1, 2'b10, 2'd2, 4'h0, 4'hA, 1'b0, l3, s3);
    checks++;
    if (RDATA3 !== 4'hA) begin
      failures++;
      $display("FAIL small_read: RDATA3=%h, required A", RDATA3);
    end
    run_txn(1, 2'b10, 2'd3, 4'h0, 4'h0, 1'b0, l3, s3);
    checks++;
    if (l3 != 2 || s3 != 0 || RDATA3 !== 4'hA) begin
      failures++;
      $display("FAIL oor_read: ack3 at %0d strobes=%0d RDATA3=%h, required 2 0 A", l3, s3, RDATA3);
    end
  endtask

  task automatic test_stability();
    int l3, s3;
    run_txn(0, 2'b01, 2'd1, 4'h3, 4'h0, 1'b1, l3, s3);
    run_txn(0, 2'b10, 2'd1, 4'h0, 4'h3, 1'b0, l3, s3);
  endtask

  task automatic test_reset_mid_read();
    int l3, s3;
    run_txn(0, 2'b10, 2'd2, 4'h0, 4'hA, 1'b0, l3, s3);
    OP0 = 2'b10; ADDR0 = 2'd2; REQ[0] = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (OE_N !== 4'b1011) begin
      failures++;
      $display("FAIL mid_read_oe: OE_N=%b, required 1011", OE_N);
    end
    CLRN = 1'b0;
    #1;
    checks++;
    if (OE_N !== 4'hF || ACK !== 2'b00 || RDATA !== 4'h0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL mid_read_reset: OE_N=%b ACK=%b RDATA=%h BUSY=%b, required 1111 00 0 0",
               OE_N, ACK, RDATA, BUSY);
    end
    REQ = 2'b00;
    @(negedge CLK);
    CLRN = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      checks++;
      if (ACK !== 2'b00 || BUSY !== 1'b0) begin
        failures++;
        $display("FAIL post_abort: ACK=%b BUSY=%b, required 00 0", ACK, BUSY);
      end
    end
  endtask

  initial begin
    CLRN = 1'b0;
    REQ = 2'b00; OP0 = 2'b00; OP1 = 2'b00;
    ADDR0 = 2'd0; ADDR1 = 2'd0; DIN0 = 4'h0; DIN1 = 4'h0;
    test_reset();
    test_load_read();
    test_contention();
    test_clear_oor();
    test_stability();
    test_reset_mid_read();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
